cluster_run_ctrl: RTL
=====================

Name: cluster_run_ctrl

Overview:
- Top-level sequencer for one processing pass through the GLB cluster, router cluster and PE cluster.
- On a run request it issues, in order:
  - one weight scratchpad load (load_spad_ctrl_wght),
  - one activation scratchpad load (load_spad_ctrl_iact),
  - NUM_ITER compute passes (pe_start), with a programmable idle gap between passes.
- Completion of each step is taken from the rising edges of the PE cluster's load_done and compute_done.
- Replaces the hand-sequenced stimulus currently used to drive these clusters.

Parameters:
NUM_ITER, 3, compute passes per run (must be >= 1; checked at elaboration)
ITER_WIDTH, 4, width of the iteration index (2**ITER_WIDTH > NUM_ITER)
GAP_CYCLES, 4, idle cycles between compute_done of pass i and pe_start of pass i+1 (0 allowed)
CNT_WIDTH, 32, performance counter width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
start_run  in  1  run request; sampled only in IDLE
abort  in  1  abandon the current run; highest priority after reset
load_done  in  1  from PE cluster: scratchpad load finished
compute_done  in  1  from PE cluster: compute pass finished
load_spad_ctrl_wght  out  1  one-cycle pulse to router cluster: load weights
load_spad_ctrl_iact  out  1  one-cycle pulse to router cluster: load activations
pe_start  out  1  one-cycle pulse to PE cluster: begin compute pass
busy  out  1  high in every state except IDLE
run_done  out  1  one-cycle pulse when all passes are complete
aborted  out  1  one-cycle pulse when abort is taken
iter_idx  out  ITER_WIDTH  index of the current or last compute pass (0-based)
total_cycles  out  CNT_WIDTH  cycles spent in the last or current run
compute_cycles  out  CNT_WIDTH  cycles spent in START_C plus WAIT_C

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All outputs = 0, including iter_idx and both counters.
  - Edge-detect registers for load_done and compute_done cleared to 0.
  - Reset asserted mid-run aborts the run immediately; no run_done and no aborted pulse is generated.
- Registered outputs: every output is a registered function of state. A pulse output is high for exactly the one cycle spent in its issuing state.
- Edge detection:
  - ld_rise = load_done & ~load_done_q.
  - cd_rise = compute_done & ~compute_done_q.
  - A level that is already high on entry to a wait state does not satisfy the wait; it must fall and then rise again.
- State machine:
  - IDLE: on start_run=1 go to LD_W; clear iter_idx and both counters.
  - LD_W: load_spad_ctrl_wght=1; go to WAIT_W.
  - WAIT_W: on ld_rise go to LD_A.
  - LD_A: load_spad_ctrl_iact=1; go to WAIT_A.
  - WAIT_A: on ld_rise go to START_C.
  - START_C: pe_start=1; go to WAIT_C.
  - WAIT_C: on cd_rise:
    - if iter_idx == NUM_ITER-1, go to DONE;
    - else if GAP_CYCLES == 0, go to START_C with iter_idx+1;
    - else go to GAP with gap counter = 0.
  - GAP: gap counter increments each cycle; when it reaches GAP_CYCLES-1, go to START_C with iter_idx+1.
  - DONE: run_done=1; go to IDLE. iter_idx holds NUM_ITER-1.
- abort=1 in any non-IDLE state goes to IDLE next cycle and pulses aborted. Counters and iter_idx hold their values.
- abort=1 in IDLE is ignored, and abort takes priority over start_run.
- start_run while busy is ignored and not queued.
- No timeout: a missing done edge stalls the FSM in its wait state until abort or reset.

Optional Feature:
- Macro: CLUSTER_RUN_PERF_CNT_EN.
- Defined:
  - total_cycles increments every cycle in states LD_W through DONE inclusive.
  - compute_cycles increments every cycle in START_C or WAIT_C.
  - Both saturate at all-ones, hold after the run, and clear on the next accepted start_run.
- Undefined: both ports remain present and are tied to 0; no counter flops are built.

Test Plan:
- Basic run (NUM_ITER=3, GAP_CYCLES=4; load_done rises 5 cycles after each load pulse; compute_done rises 10 cycles after each pe_start) -> wght pulse, then iact pulse, then 3 pe_start pulses, then a single run_done; iter_idx = 2; compute_cycles = 33; total_cycles = 54.
- load_done held high from the previous load across LD_A -> no advance until load_done falls and rises again; load_spad_ctrl_iact pulses exactly once.
- abort asserted while in WAIT_C of pass 1 -> aborted pulses 1 cycle later; busy=0; no further pe_start; iter_idx = 1.
- start_run held high throughout a run -> exactly one run executes; a new run begins on the cycle after DONE, since the FSM is back in IDLE; counters reset to 0 at that point.
- reset asserted asynchronously mid-GAP -> all outputs 0 in the same cycle with no clock edge required; a subsequent start_run executes a full run normally.
- GAP_CYCLES=0, NUM_ITER=1 -> exactly one pe_start; run_done 1 cycle after cd_rise; compute_cycles = 11.

Source files
------------

// File: rtl/cluster_run_ctrl.sv
// Run sequencer for one GLB/router/PE pass: weight load, activation load, then NUM_ITER compute passes.
// Outputs are registered from the next state; the perf counters exist only with CLUSTER_RUN_PERF_CNT_EN defined.
module cluster_run_ctrl #(
    parameter int NUM_ITER   = 3,
    parameter int ITER_WIDTH = 4,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_run,
    input  logic                  abort,
    input  logic                  load_done,
    input  logic                  compute_done,
    output logic                  load_spad_ctrl_wght,
    output logic                  load_spad_ctrl_iact,
    output logic                  pe_start,
    output logic                  busy,
    output logic                  run_done,
    output logic                  aborted,
    output logic [ITER_WIDTH-1:0] iter_idx,
    output logic [CNT_WIDTH-1:0]  total_cycles,
    output logic [CNT_WIDTH-1:0]  compute_cycles
);

    typedef enum logic [3:0] {
        IDLE, LD_W, WAIT_W, LD_A, WAIT_A, START_C, WAIT_C, GAP, DONE
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ITER_WIDTH-1:0] ITER_LAST = ITER_WIDTH'(NUM_ITER - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (NUM_ITER < 1) begin : g_bad_num_iter
        $error("cluster_run_ctrl: NUM_ITER must be >= 1");
    end
    if ((1 << ITER_WIDTH) <= NUM_ITER) begin : g_bad_iter_width
        $error("cluster_run_ctrl: ITER_WIDTH too narrow for NUM_ITER");
    end

    state_t                state, state_nxt;
    logic                  load_done_q, compute_done_q;
    logic                  ld_rise, cd_rise;
    logic                  run_start, abort_take;
    logic [ITER_WIDTH-1:0] iter_nxt;
    logic [GAP_W-1:0]      gap_cnt, gap_nxt;

    // Only fresh rising edges count, so a level left high by an earlier step never satisfies a wait.
    assign ld_rise    = load_done & ~load_done_q;
    assign cd_rise    = compute_done & ~compute_done_q;
    assign run_start  = (state == IDLE) & start_run & ~abort;
    assign abort_take = (state != IDLE) & abort;

    always_comb begin
        state_nxt = state;
        iter_nxt  = iter_idx;
        gap_nxt   = gap_cnt;
        if (abort_take) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run_start) begin
                        state_nxt = LD_W;
                        iter_nxt  = '0;
                    end
                end
                LD_W:    state_nxt = WAIT_W;
                WAIT_W:  if (ld_rise) state_nxt = LD_A;
                LD_A:    state_nxt = WAIT_A;
                WAIT_A:  if (ld_rise) state_nxt = START_C;
                START_C: state_nxt = WAIT_C;
                WAIT_C: begin
                    if (cd_rise) begin
                        if (iter_idx == ITER_LAST) begin
                            state_nxt = DONE;
                        end else if (GAP_CYCLES == 0) begin
                            state_nxt = START_C;
                            iter_nxt  = iter_idx + 1'b1;
                        end else begin
                            state_nxt = GAP;
                            gap_nxt   = '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt = START_C;
                        iter_nxt  = iter_idx + 1'b1;
                    end else begin
                        gap_nxt = gap_cnt + 1'b1;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            load_done_q         <= 1'b0;
            compute_done_q      <= 1'b0;
            iter_idx            <= '0;
            gap_cnt             <= '0;
            load_spad_ctrl_wght <= 1'b0;
            load_spad_ctrl_iact <= 1'b0;
            pe_start            <= 1'b0;
            busy                <= 1'b0;
            run_done            <= 1'b0;
            aborted             <= 1'b0;
        end else begin
            state               <= state_nxt;
            load_done_q         <= load_done;
            compute_done_q      <= compute_done;
            iter_idx            <= iter_nxt;
            gap_cnt             <= gap_nxt;
            load_spad_ctrl_wght <= (state_nxt == LD_W);
            load_spad_ctrl_iact <= (state_nxt == LD_A);
            pe_start            <= (state_nxt == START_C);
            busy                <= (state_nxt != IDLE);
            run_done            <= (state_nxt == DONE);
            aborted             <= abort_take;
        end
    end

`ifdef CLUSTER_RUN_PERF_CNT_EN
    logic in_compute;
    assign in_compute = (state == START_C) || (state == WAIT_C);

    // Saturating counters; they freeze once the FSM is back in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_cycles   <= '0;
            compute_cycles <= '0;
        end else if (run_start) begin
            total_cycles   <= '0;
            compute_cycles <= '0;
        end else if (state != IDLE) begin
            if (total_cycles != '1) total_cycles <= total_cycles + 1'b1;
            if (in_compute && (compute_cycles != '1)) compute_cycles <= compute_cycles + 1'b1;
        end
    end
`else
    assign total_cycles   = '0;
    assign compute_cycles = '0;
`endif

endmodule
